// File: rtl/decode_issue_queue_pkg.sv
// Shared types for the decode issue queue: field widths, format/unit codes,
// and the packed queue entry with its pack/unpack helpers.
package decode_issue_pkg;

  localparam int ADDRESS_SIZE       = 64;
  localparam int OPCODE_WIDTH       = 6;
  localparam int REG_WIDTH          = 5;
  localparam int IMM_WIDTH          = 16;
  localparam int XOPCODE_WIDTH      = 10;
  localparam int FORMAT_INDEX_RANGE = 5;
  localparam int FU_CODE_WIDTH      = 3;

  // Instruction format codes; the codes between A and Z23 follow the ISA format table.
  localparam logic [FORMAT_INDEX_RANGE-1:0] FMT_INVALID = 5'd0;
  localparam logic [FORMAT_INDEX_RANGE-1:0] FMT_A       = 5'd1;
  localparam logic [FORMAT_INDEX_RANGE-1:0] FMT_Z23     = 5'd25;

  localparam logic [FU_CODE_WIDTH-1:0] FU_INTEGER    = 3'd0;
  localparam logic [FU_CODE_WIDTH-1:0] FU_LOAD_STORE = 3'd1;
  localparam logic [FU_CODE_WIDTH-1:0] FU_BRANCH     = 3'd2;
  localparam logic [FU_CODE_WIDTH-1:0] FU_FLOAT      = 3'd3;
  localparam logic [FU_CODE_WIDTH-1:0] FU_SYSTEM     = 3'd4;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0]       instruction_address;
    logic [OPCODE_WIDTH-1:0]       opcode;
    logic [XOPCODE_WIDTH-1:0]      x_opcode;
    logic                          x_opcode_enable;
    logic [IMM_WIDTH-1:0]          imm;
    logic                          imm_enable;
    logic [REG_WIDTH-1:0]          reg1;
    logic [REG_WIDTH-1:0]          reg2;
    logic [REG_WIDTH-1:0]          reg3;
    logic [1:0]                    reg1_use;
    logic [1:0]                    reg2_use;
    logic [1:0]                    reg3_use;
    logic                          reg1_enable;
    logic                          reg2_enable;
    logic                          reg3_enable;
    logic                          reg3_is_immediate;
    logic                          bit1;
    logic                          bit2;
    logic                          bit1_enable;
    logic                          bit2_enable;
    logic                          reg2_val_or_zero;
    logic [FU_CODE_WIDTH-1:0]      functional_unit_code;
    logic [FORMAT_INDEX_RANGE-1:0] instruction_format;
  } entry_t;

  localparam int ENTRY_WIDTH = $bits(entry_t);

  function automatic logic [ENTRY_WIDTH-1:0] pack_entry(input entry_t e);
    return e;
  endfunction

  function automatic entry_t unpack_entry(input logic [ENTRY_WIDTH-1:0] v);
    return entry_t'(v);
  endfunction

endpackage

// File: rtl/decode_issue_queue_if.sv
// Decode-bus / issue-handshake bundle between the decode mux stage, the
// issue queue (slave) and the issue stage; the master is the surrounding pipeline.
interface decode_issue_queue_if #(parameter int DEPTH = 8);
  import decode_issue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                          flush_i;
  logic                          enable_i;
  logic                          ready_i;
  logic [ADDRESS_SIZE-1:0]       instructionAddress_i, instructionAddress_o;
  logic [OPCODE_WIDTH-1:0]       opcode_i, opcode_o;
  logic [XOPCODE_WIDTH-1:0]      xOpcode_i, xOpcode_o;
  logic                          xOpcodeEnable_i, xOpcodeEnable_o;
  logic [IMM_WIDTH-1:0]          imm_i, imm_o;
  logic                          immEnable_i, immEnable_o;
  logic [REG_WIDTH-1:0]          reg1_i, reg1_o, reg2_i, reg2_o, reg3_i, reg3_o;
  logic [1:0]                    reg1Use_i, reg1Use_o, reg2Use_i, reg2Use_o, reg3Use_i, reg3Use_o;
  logic                          reg1Enable_i, reg1Enable_o, reg2Enable_i, reg2Enable_o;
  logic                          reg3Enable_i, reg3Enable_o;
  logic                          reg3IsImmediate_i, reg3IsImmediate_o;
  logic                          bit1_i, bit1_o, bit2_i, bit2_o;
  logic                          bit1Enable_i, bit1Enable_o, bit2Enable_i, bit2Enable_o;
  logic                          reg2ValOrZero_i, reg2ValOrZero_o;
  logic [FU_CODE_WIDTH-1:0]      functionalUnitCode_i, functionalUnitCode_o;
  logic [FORMAT_INDEX_RANGE-1:0] instructionFormat_i, instructionFormat_o;
  logic                          stall_o;
  logic                          overflow_o;
  logic [CNT_W-1:0]              count_o;
  logic                          valid_o;

  modport master (
    output flush_i, enable_i, ready_i, instructionAddress_i, opcode_i, xOpcode_i,
           xOpcodeEnable_i, imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
           reg1Use_i, reg2Use_i, reg3Use_i, reg1Enable_i, reg2Enable_i, reg3Enable_i,
           reg3IsImmediate_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
           reg2ValOrZero_i, functionalUnitCode_i, instructionFormat_i,
    input  instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o, imm_o,
           immEnable_o, reg1_o, reg2_o, reg3_o, reg1Use_o, reg2Use_o, reg3Use_o,
           reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, bit1_o,
           bit2_o, bit1Enable_o, bit2Enable_o, reg2ValOrZero_o, functionalUnitCode_o,
           instructionFormat_o, stall_o, overflow_o, count_o, valid_o
  );

  modport slave (
    input  flush_i, enable_i, ready_i, instructionAddress_i, opcode_i, xOpcode_i,
           xOpcodeEnable_i, imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
           reg1Use_i, reg2Use_i, reg3Use_i, reg1Enable_i, reg2Enable_i, reg3Enable_i,
           reg3IsImmediate_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
           reg2ValOrZero_i, functionalUnitCode_i, instructionFormat_i,
    output instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o, imm_o,
           immEnable_o, reg1_o, reg2_o, reg3_o, reg1Use_o, reg2Use_o, reg3Use_o,
           reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o, bit1_o,
           bit2_o, bit1Enable_o, bit2Enable_o, reg2ValOrZero_o, functionalUnitCode_o,
           instructionFormat_o, stall_o, overflow_o, count_o, valid_o
  );

endinterface

// File: rtl/decode_issue_queue_storage.sv
// Entry storage for the issue queue: DEPTH x WIDTH registers with one
// synchronous write port and one asynchronous read port.
module issue_queue_storage #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 136
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; an entry is only ever read after it was written,
  // so clearing it would buy nothing but a wide reset fan-out.
  always_ff @(posedge i_clk) begin
    // NOTE: registered state always uses <= so every flop samples pre-edge values.
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/decode_issue_queue.sv
// In-order issue queue behind the decode mux stage, with early stall and sticky overflow.
// Optional same-cycle bypass into an empty queue: define DECODE_ISSUE_QUEUE_BYPASS_EN.
module decode_issue_queue
  import decode_issue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_SLACK = 2
) (
  input logic               clock_i,
  input logic               reset_i,
  decode_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - STALL_SLACK);

  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count, w_count_next;
  logic                   r_stall, r_overflow;
  logic                   w_empty, w_full, w_valid, w_pop, w_push, w_drop, w_we;
  logic [ENTRY_WIDTH-1:0] w_rd_data;
  entry_t                 w_in_entry, w_head_entry, w_out_entry, w_out_masked;

  assign w_in_entry = '{
    instruction_address:  bus.instructionAddress_i, opcode: bus.opcode_i,
    x_opcode:             bus.xOpcode_i,            x_opcode_enable: bus.xOpcodeEnable_i,
    imm:                  bus.imm_i,                imm_enable: bus.immEnable_i,
    reg1:                 bus.reg1_i,  reg2: bus.reg2_i,  reg3: bus.reg3_i,
    reg1_use:             bus.reg1Use_i, reg2_use: bus.reg2Use_i, reg3_use: bus.reg3Use_i,
    reg1_enable:          bus.reg1Enable_i, reg2_enable: bus.reg2Enable_i,
    reg3_enable:          bus.reg3Enable_i, reg3_is_immediate: bus.reg3IsImmediate_i,
    bit1:                 bus.bit1_i, bit2: bus.bit2_i,
    bit1_enable:          bus.bit1Enable_i, bit2_enable: bus.bit2Enable_i,
    reg2_val_or_zero:     bus.reg2ValOrZero_i,
    functional_unit_code: bus.functionalUnitCode_i,
    instruction_format:   bus.instructionFormat_i
  };

  issue_queue_storage #(.DEPTH(DEPTH), .WIDTH(ENTRY_WIDTH)) u_storage (
    .i_clk   (clock_i),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (pack_entry(w_in_entry)),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign w_head_entry = unpack_entry(w_rd_data);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_LEVEL);

`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
  logic w_bypass;
  // An instruction arriving at an empty queue is offered straight to issue; it is
  // only written when issue does not take it this cycle.
  assign w_bypass    = w_empty & bus.enable_i;
  assign w_valid     = ~w_empty | w_bypass;
  assign w_pop       = ~w_empty & bus.ready_i;
  assign w_push      = bus.enable_i & (~w_full | w_pop) & ~(w_bypass & bus.ready_i);
  assign w_out_entry = w_bypass ? w_in_entry : w_head_entry;
`else
  assign w_valid     = ~w_empty;
  assign w_pop       = w_valid & bus.ready_i;
  assign w_push      = bus.enable_i & (~w_full | w_pop);
  assign w_out_entry = w_head_entry;
`endif

  assign w_we   = w_push & ~bus.flush_i;
  assign w_drop = bus.enable_i & w_full & ~w_pop & ~bus.flush_i;

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    w_count_next = r_count;
    if (bus.flush_i) w_count_next = '0;
    else             w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      // Stall is raised early so instructions already in decode still find a slot.
      r_stall <= (w_count_next >= STALL_LEVEL);
      if (bus.flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_out_masked = w_valid ? w_out_entry : '0;

  assign bus.valid_o              = w_valid;
  assign bus.count_o              = r_count;
  assign bus.stall_o              = r_stall;
  assign bus.overflow_o           = r_overflow;
  assign bus.instructionAddress_o = w_out_masked.instruction_address;
  assign bus.opcode_o             = w_out_masked.opcode;
  assign bus.xOpcode_o            = w_out_masked.x_opcode;
  assign bus.xOpcodeEnable_o      = w_out_masked.x_opcode_enable;
  assign bus.imm_o                = w_out_masked.imm;
  assign bus.immEnable_o          = w_out_masked.imm_enable;
  assign bus.reg1_o               = w_out_masked.reg1;
  assign bus.reg2_o               = w_out_masked.reg2;
  assign bus.reg3_o               = w_out_masked.reg3;
  assign bus.reg1Use_o            = w_out_masked.reg1_use;
  assign bus.reg2Use_o            = w_out_masked.reg2_use;
  assign bus.reg3Use_o            = w_out_masked.reg3_use;
  assign bus.reg1Enable_o         = w_out_masked.reg1_enable;
  assign bus.reg2Enable_o         = w_out_masked.reg2_enable;
  assign bus.reg3Enable_o         = w_out_masked.reg3_enable;
  assign bus.reg3IsImmediate_o    = w_out_masked.reg3_is_immediate;
  assign bus.bit1_o               = w_out_masked.bit1;
  assign bus.bit2_o               = w_out_masked.bit2;
  assign bus.bit1Enable_o         = w_out_masked.bit1_enable;
  assign bus.bit2Enable_o         = w_out_masked.bit2_enable;
  assign bus.reg2ValOrZero_o      = w_out_masked.reg2_val_or_zero;
  assign bus.functionalUnitCode_o = w_out_masked.functional_unit_code;
  assign bus.instructionFormat_o  = w_out_masked.instruction_format;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Table-driven bench for decode_issue_queue (DEPTH=8, STALL_SLACK=2): ordering,
// stall threshold, overflow, full push+pop, flush, reset and pointer wrap.
module tb_decode_issue_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_queue_if #(.DEPTH(8)) bus ();

  decode_issue_queue #(.DEPTH(8), .STALL_SLACK(2)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // Constant side-band fields, in output concatenation order below.
  localparam logic [55:0] SIDE = {6'h2B, 10'h155, 1'b1, 1'b1, 5'h03, 5'h11, 5'h1E,
                                  2'b01, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 5'd25};

  typedef struct {
    logic        rst, en, rdy, fl;
    logic [63:0] addr;
    logic [15:0] imm;
    logic [3:0]  e_cnt;
    logic        e_vld;
    logic [63:0] e_addr;
    logic [15:0] e_imm;
    logic        e_stall, e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [55:0] side_out();
    return {bus.opcode_o, bus.xOpcode_o, bus.xOpcodeEnable_o, bus.immEnable_o,
            bus.reg1_o, bus.reg2_o, bus.reg3_o, bus.reg1Use_o, bus.reg2Use_o,
            bus.reg3Use_o, bus.reg1Enable_o, bus.reg2Enable_o, bus.reg3Enable_o,
            bus.reg3IsImmediate_o, bus.bit1_o, bus.bit2_o, bus.bit1Enable_o,
            bus.bit2Enable_o, bus.reg2ValOrZero_o, bus.functionalUnitCode_o,
            bus.instructionFormat_o};
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  function automatic void add(input logic r, input logic en, input logic rdy, input logic fl,
                              input logic [63:0] addr, input logic [15:0] imm,
                              input int cnt, input logic vld, input logic [63:0] eaddr,
                              input logic [15:0] eimm, input logic st, input logic ov);
    vec_t v;
    v.rst = r; v.en = en; v.rdy = rdy; v.fl = fl; v.addr = addr; v.imm = imm;
    v.e_cnt = 4'(cnt); v.e_vld = vld; v.e_addr = eaddr; v.e_imm = eimm;
    v.e_stall = st; v.e_ovf = ov;
    vecs.push_back(v);
  endfunction

  task automatic release_inputs();
    rst = 1'b0; bus.enable_i = 1'b0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic check_state(input int idx, input vec_t v);
    check("count_o",  idx, 64'(bus.count_o), 64'(v.e_cnt));
    check("valid_o",  idx, 64'(bus.valid_o), 64'(v.e_vld));
    check("addr_o",   idx, bus.instructionAddress_o, v.e_addr);
    check("imm_o",    idx, 64'(bus.imm_o), 64'(v.e_imm));
    check("stall_o",  idx, 64'(bus.stall_o), 64'(v.e_stall));
    check("overflow", idx, 64'(bus.overflow_o), 64'(v.e_ovf));
    check("side_o",   idx, 64'(side_out()), v.e_vld ? 64'(SIDE) : 64'd0);
  endtask

  initial begin
    bus.flush_i = 1'b0; bus.enable_i = 1'b0; bus.ready_i = 1'b0;
    bus.instructionAddress_i = '0; bus.imm_i = '0;
    {bus.opcode_i, bus.xOpcode_i, bus.xOpcodeEnable_i, bus.immEnable_i,
     bus.reg1_i, bus.reg2_i, bus.reg3_i, bus.reg1Use_i, bus.reg2Use_i, bus.reg3Use_i,
     bus.reg1Enable_i, bus.reg2Enable_i, bus.reg3Enable_i, bus.reg3IsImmediate_i,
     bus.bit1_i, bus.bit2_i, bus.bit1Enable_i, bus.bit2Enable_i, bus.reg2ValOrZero_i,
     bus.functionalUnitCode_i, bus.instructionFormat_i} = SIDE;

    // Reset, three pushes, drain in order
    add(1,0,0,0, 0,0,       0,0,0,0,0,0);
    add(0,1,0,0, 'h100,1,   1,1,'h100,1,0,0);
    add(0,1,0,0, 'h104,2,   2,1,'h100,1,0,0);
    add(0,1,0,0, 'h108,3,   3,1,'h100,1,0,0);
    add(0,0,1,0, 0,0,       2,1,'h104,2,0,0);
    add(0,0,1,0, 0,0,       1,1,'h108,3,0,0);
    add(0,0,1,0, 0,0,       0,0,0,0,0,0);
    // Fill: stall once count reaches 6, 9th push overflows
    add(1,0,0,0, 0,0,       0,0,0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0,0, 64'('h1000 + 4*i), 16'(16 + i), i+1,1,'h1000,16, (i+1) >= 6, 0);
    add(0,1,0,0, 'h1020,99, 8,1,'h1000,16,1,1);
    // Full with push+pop: slot reused, no overflow, new entry at tail
    add(1,0,0,0, 0,0,       0,0,0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0,0, 64'('h2000 + 4*i), 16'('h20 + i), i+1,1,'h2000,'h20, (i+1) >= 6, 0);
    add(0,1,1,0, 'h2100,'h99, 8,1,'h2004,'h21,1,0);
    for (int k = 1; k <= 7; k++)
      add(0,0,1,0, 0,0, 8-k,1, (k < 7) ? 64'('h2004 + 4*k) : 64'h2100,
          (k < 7) ? 16'('h21 + k) : 16'h99, (8-k) >= 6, 0);
    add(0,0,1,0, 0,0,       0,0,0,0,0,0);
    // Overflow, drain to 5, flush with enable; overflow persists
    add(1,0,0,0, 0,0,       0,0,0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,1,0,0, 64'('h3000 + 4*i), 16'('h30 + i), i+1,1,'h3000,'h30, (i+1) >= 6, 0);
    add(0,1,0,0, 'h3100,'h77, 8,1,'h3000,'h30,1,1);
    for (int k = 1; k <= 3; k++)
      add(0,0,1,0, 0,0, 8-k,1, 64'('h3000 + 4*k), 16'('h30 + k), (8-k) >= 6, 1);
    add(0,1,0,1, 'h3333,'h33, 0,0,0,0,0,1);
    add(0,1,0,0, 'h4000,'h40, 1,1,'h4000,'h40,0,1);
    // Pointer wrap: 20 push/pop pairs
    add(1,0,0,0, 0,0,       0,0,0,0,0,0);
    add(0,1,0,0, 'h5000,0,  1,1,'h5000,0,0,0);
    for (int i = 1; i < 20; i++)
      add(0,1,1,0, 64'('h5000 + i), 16'(i), 1,1, 64'('h5000 + i), 16'(i), 0,0);
    add(0,0,1,0, 0,0,       0,0,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; bus.enable_i = vecs[i].en; bus.ready_i = vecs[i].rdy;
      bus.flush_i = vecs[i].fl;
      bus.instructionAddress_i = vecs[i].addr; bus.imm_i = vecs[i].imm;
      @(posedge clk);
      #1;
      release_inputs();
      check_state(i, vecs[i]);
    end

`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
    // Empty queue, enable+ready: issued in the same cycle, never written
    @(negedge clk);
    bus.enable_i = 1'b1; bus.ready_i = 1'b1;
    bus.instructionAddress_i = 64'h200; bus.imm_i = 16'h5;
    #1;
    check("bypass_valid", 0, 64'(bus.valid_o), 64'd1);
    check("bypass_addr",  0, bus.instructionAddress_o, 64'h200);
    check("bypass_count", 0, 64'(bus.count_o), 64'd0);
    @(posedge clk);
    #1;
    release_inputs();
    check("bypass_count_after", 0, 64'(bus.count_o), 64'd0);
    check("bypass_valid_after", 0, 64'(bus.valid_o), 64'd0);
`else
    // Empty queue, enable+ready: nothing dequeued this cycle, entry pushed only
    @(negedge clk);
    bus.enable_i = 1'b1; bus.ready_i = 1'b1;
    bus.instructionAddress_i = 64'h600; bus.imm_i = 16'h6;
    #1;
    check("empty_valid", 0, 64'(bus.valid_o), 64'd0);
    check("empty_addr",  0, bus.instructionAddress_o, 64'd0);
    @(posedge clk);
    #1;
    release_inputs();
    check("empty_push_count", 0, 64'(bus.count_o), 64'd1);
    check("empty_push_addr",  0, bus.instructionAddress_o, 64'h600);
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    release_inputs();
    check("empty_drain_count", 0, 64'(bus.count_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- In-order FIFO buffer directly downstream of the second decode (mux) stage.
- Captures the single multiplexed decoded-instruction bus every cycle it is valid.
- Presents entries oldest-first to the issue/dispatch stage over a valid/ready handshake.
- The decode pipeline has no ready input, so the queue raises an early stall so in-flight instructions still land; it flags overflow if one is lost.

Parameters:
- DEPTH, 8, entries; power of 2, minimum 4.
- STALL_SLACK, 2, free slots reserved for in-flight decode instructions when stall_o asserts.
- addressSize, 64, instruction address width.
- opcodeWidth, 6, primary opcode width.
- regWidth, 5, register specifier width.
- immWidth, 16, immediate width.
- xOpcodeWidth, 10, extended opcode width.
- formatIndexRange, 5, instruction format code width.

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries
- enable_i  in  1  decode bus valid this cycle
- instructionAddress_i  in  64  instruction address
- opcode_i  in  6  primary opcode
- xOpcode_i  in  10  extended opcode
- xOpcodeEnable_i  in  1  extended opcode valid
- imm_i  in  16  immediate
- immEnable_i  in  1  immediate valid
- reg1_i / reg2_i / reg3_i  in  5 each  register specifiers
- reg1Use_i / reg2Use_i / reg3Use_i  in  2 each  register read/write use codes
- reg1Enable_i / reg2Enable_i / reg3Enable_i  in  1 each  register specifier valid
- reg3IsImmediate_i  in  1  reg3 field carries an immediate
- bit1_i / bit2_i  in  1 each  format flag bits
- bit1Enable_i / bit2Enable_i  in  1 each  flag bits valid
- reg2ValOrZero_i  in  1  RA=0 means literal zero
- functionalUnitCode_i  in  3  target functional unit
- instructionFormat_i  in  5  format code
- stall_o  out  1  request decode/fetch to stop
- overflow_o  out  1  sticky: instruction dropped while full
- count_o  out  log2(DEPTH)+1  current occupancy
- valid_o  out  1  head entry valid
- ready_i  in  1  issue stage accepts head
- each *_i data field above has a matching *_o output of the same width, showing the head entry

Behaviour:
- Entry payload is 136 bits: all *_i data fields concatenated.
- Occupancy, pointers:
  - wrPtr, rdPtr are log2(DEPTH) bits and wrap modulo DEPTH; count tracks occupancy.
  - push = enable_i & (count < DEPTH | pop).
  - pop = valid_o & ready_i.
- Head output:
  - valid_o = (count != 0).
  - Data outputs are driven combinationally from the entry at rdPtr.
  - All data outputs are forced to 0 when valid_o = 0.
- Latency:
  - An entry pushed at edge N is visible no earlier than the cycle after edge N.
  - Minimum enqueue-to-valid latency is 1 cycle.
- Simultaneous push and pop: count unchanged; both pointers advance. This holds when full: the slot freed this cycle is reused.
- Empty with enable_i = 1 and ready_i = 1: push only; nothing is dequeued that cycle.
- Full, enable_i = 1, no pop:
  - The instruction is dropped; wrPtr and count are unchanged.
  - overflow_o is set and stays 1 until reset.
- stall_o:
  - Registered; next value is (count_next >= DEPTH - STALL_SLACK).
  - A single push that crosses the threshold raises stall_o in the following cycle.
- flush_i (takes priority over push and pop in the same cycle):
  - count, wrPtr and rdPtr go to 0; stall_o goes to 0.
  - A same-cycle enable_i is discarded.
  - overflow_o is not cleared.
- Reset (also mid-operation):
  - count, wrPtr, rdPtr, stall_o, overflow_o go to 0.
  - As a result valid_o = 0 and all data outputs = 0.
  - Storage contents are not cleared.
- No state machine beyond pointers/count. States are EMPTY, PARTIAL, FULL; they are derived from count, not encoded separately.

Optional Feature:
- Macro: DECODE_ISSUE_QUEUE_BYPASS_EN.
- Defined: when count = 0 and enable_i = 1:
  - valid_o is asserted in the same cycle and the data outputs show the *_i fields.
  - If ready_i = 1 as well, the instruction is issued without being written; count stays 0.
  - If ready_i = 0, it is written normally.
  - Zero-cycle latency in the empty case.
- Undefined: no bypass path; minimum latency 1 cycle as above.

Decomposition:
- Package decode_issue_pkg holds:
  - format code constants (INVALID=0, A=1 … Z23=25);
  - functional-unit code constants;
  - ENTRY_WIDTH;
  - the packed entry struct type with its pack/unpack helpers.
- One sub-module, issue_queue_storage:
  - DEPTH x ENTRY_WIDTH register array;
  - one synchronous write port, one asynchronous read port;
  - no reset.

Test Plan:
- Reset, then 3 pushes with addresses 0x100/0x104/0x108, ready_i=0 → count_o=3, valid_o=1, instructionAddress_o=0x100; ready_i=1 for 3 cycles → outputs 0x100, 0x104, 0x108 in order, then valid_o=0 with all data outputs 0.
- DEPTH=8, STALL_SLACK=2, ready_i=0, push continuously → stall_o rises the cycle after count reaches 6; 9th push sets overflow_o=1 and count_o stays 8.
- Full queue, enable_i=1 and ready_i=1 the same cycle → count_o stays 8; new entry appears at the tail after 7 further pops; overflow_o stays 0.
- 5 entries queued, flush_i=1 with enable_i=1 → next cycle count_o=0, valid_o=0, stall_o=0; a previously set overflow_o remains 1.
- Wrap-around: 20 push/pop pairs with imm_i incrementing 0..19 → imm_o sequence 0..19 exactly, no loss or duplication across pointer wrap.
- With DECODE_ISSUE_QUEUE_BYPASS_EN, empty queue, enable_i=1, ready_i=1, address 0x200 → valid_o=1 and instructionAddress_o=0x200 the same cycle, count_o stays 0.
